// File: rtl/tetris_pkg.sv
// Shared constants and types for the tetris game-flow logic:
// board size, piece codes, sequencer states and request priority.
package tetris_pkg;

  localparam int BOARD_WIDTH  = 10;
  localparam int BOARD_HEIGHT = 20;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_SPAWN_CHK,
    ST_FALL,
    ST_TRY,
    ST_LOCK,
    ST_SETTLE,
    ST_GAME_OVER
  } seq_state_t;

  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_DROP,
    REQ_DOWN,
    REQ_ROT,
    REQ_LEFT,
    REQ_RIGHT
  } req_t;

  localparam int PEND_W     = 5;
  localparam int PEND_RIGHT = 0;
  localparam int PEND_LEFT  = 1;
  localparam int PEND_ROT   = 2;
  localparam int PEND_DOWN  = 3;
  localparam int PEND_DROP  = 4;

  // Highest-priority pending request: drop > down > rot > left > right.
  function automatic req_t pick_request(input logic [PEND_W-1:0] pend);
    if (pend[PEND_DROP])  return REQ_DROP;
    if (pend[PEND_DOWN])  return REQ_DOWN;
    if (pend[PEND_ROT])   return REQ_ROT;
    if (pend[PEND_LEFT])  return REQ_LEFT;
    if (pend[PEND_RIGHT]) return REQ_RIGHT;
    return REQ_NONE;
  endfunction

  function automatic logic [PEND_W-1:0] req_mask(input req_t req);
    logic [PEND_W-1:0] m;
    m = '0;
    case (req)
      REQ_DROP:  m[PEND_DROP]  = 1'b1;
      REQ_DOWN:  m[PEND_DOWN]  = 1'b1;
      REQ_ROT:   m[PEND_ROT]   = 1'b1;
      REQ_LEFT:  m[PEND_LEFT]  = 1'b1;
      REQ_RIGHT: m[PEND_RIGHT] = 1'b1;
      default:   m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/piece_rng.sv
// Next-piece generator: 8-bit Fibonacci LFSR (taps 8,6,5,4) with the
// low three bits folded onto the seven piece codes.
module piece_rng
  import tetris_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [2:0] piece
);

  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (en) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // Code 7 has no piece; fold it onto the I piece.
  assign piece = (lfsr[2:0] == 3'd7) ? 3'(PIECE_I) : lfsr[2:0];

endmodule

// File: rtl/piece_sequencer.sv
// Game-flow controller: owns the falling piece, turns requests and gravity
// into trial positions, and commits or rejects them using the playfield collision flag.
module piece_sequencer
  import tetris_pkg::*;
#(
  parameter int         BOARD_WIDTH  = tetris_pkg::BOARD_WIDTH,
  parameter int         BOARD_HEIGHT = tetris_pkg::BOARD_HEIGHT,
  parameter int         SPAWN_X      = 3,
  parameter int         GRAVITY_DIV  = 25000000,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            btn_left,
  input  logic                            btn_right,
  input  logic                            btn_rot,
  input  logic                            btn_drop,
  input  logic                            collision,
  output logic [$clog2(BOARD_WIDTH)-1:0]  cur_x,
  output logic [$clog2(BOARD_HEIGHT)-1:0] cur_y,
  output logic [2:0]                      cur_piece,
  output logic [1:0]                      cur_rotation,
  output logic                            place_piece,
  output logic                            game_over,
  output logic [15:0]                     pieces_placed
);

  localparam int XW = $clog2(BOARD_WIDTH);
  localparam int YW = $clog2(BOARD_HEIGHT);
  localparam int GW = $clog2(GRAVITY_DIV);

  seq_state_t        state;
  req_t              try_req;
  req_t              sel;
  logic [XW-1:0]     com_x;
  logic [YW-1:0]     com_y;
  logic [1:0]        com_rot;
  logic [PEND_W-1:0] pending;
  logic [PEND_W-1:0] pending_next;
  logic [PEND_W-1:0] clr_mask;
  logic [PEND_W-1:0] set_mask;
  logic [GW-1:0]     grav_cnt;
  logic              grav_tick;
  logic              accept_btn;
  logic              rng_en;
  logic [2:0]        rng_piece;

  assign rng_en     = (state != ST_IDLE);
  assign accept_btn = (state == ST_FALL) || (state == ST_TRY) ||
                      (state == ST_LOCK) || (state == ST_SETTLE);
  assign grav_tick  = ((state == ST_FALL) || (state == ST_TRY)) &&
                      (grav_cnt == GW'(GRAVITY_DIV - 1));
  assign sel        = pick_request(pending);

  piece_rng #(.LFSR_SEED(LFSR_SEED)) u_rng (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rng_en),
    .piece (rng_piece)
  );

  // A new request arriving in the same cycle its bit is serviced must survive.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (state == ST_FALL && sel == REQ_LEFT && com_x == '0) begin
      clr_mask[PEND_LEFT] = 1'b1;
    end else if (state == ST_TRY) begin
      clr_mask = req_mask(try_req);
    end
    if (accept_btn) begin
      set_mask[PEND_DROP]  = btn_drop;
      set_mask[PEND_ROT]   = btn_rot;
      set_mask[PEND_LEFT]  = btn_left;
      set_mask[PEND_RIGHT] = btn_right;
    end
    set_mask[PEND_DOWN] = grav_tick;
    pending_next = (state == ST_SPAWN) ? '0 : ((pending & ~clr_mask) | set_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      grav_cnt <= '0;
    end else begin
      pending <= pending_next;
      if (state == ST_SPAWN) begin
        grav_cnt <= '0;
      end else if (state == ST_FALL || state == ST_TRY) begin
        grav_cnt <= grav_tick ? '0 : grav_cnt + GW'(1);
      end
    end
  end

  // cur_* carry the trial position during TRY and mirror com_* otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      try_req       <= REQ_NONE;
      com_x         <= '0;
      com_y         <= '0;
      com_rot       <= '0;
      cur_x         <= '0;
      cur_y         <= '0;
      cur_piece     <= '0;
      cur_rotation  <= '0;
      place_piece   <= 1'b0;
      game_over     <= 1'b0;
      pieces_placed <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_SPAWN;
        end
        ST_SPAWN: begin
          cur_piece    <= rng_piece;
          com_x        <= XW'(SPAWN_X);
          com_y        <= '0;
          com_rot      <= '0;
          cur_x        <= XW'(SPAWN_X);
          cur_y        <= '0;
          cur_rotation <= '0;
          state        <= ST_SPAWN_CHK;
        end
        ST_SPAWN_CHK: begin
          if (collision) begin
            game_over <= 1'b1;
            state     <= ST_GAME_OVER;
          end else begin
            state <= ST_FALL;
          end
        end
        ST_FALL: begin
          case (sel)
            REQ_DROP, REQ_DOWN: begin
              cur_y   <= com_y + YW'(1);
              try_req <= sel;
              state   <= ST_TRY;
            end
            REQ_ROT: begin
              cur_rotation <= com_rot + 2'd1;
              try_req      <= sel;
              state        <= ST_TRY;
            end
            REQ_LEFT: begin
              if (com_x != '0) begin
                cur_x   <= com_x - XW'(1);
                try_req <= sel;
                state   <= ST_TRY;
              end
            end
            REQ_RIGHT: begin
              cur_x   <= com_x + XW'(1);
              try_req <= sel;
              state   <= ST_TRY;
            end
            default: ;
          endcase
        end
        ST_TRY: begin
          if (!collision) begin
            com_x   <= cur_x;
            com_y   <= cur_y;
            com_rot <= cur_rotation;
            if (try_req == REQ_DROP) begin
              cur_y <= cur_y + YW'(1);
            end else begin
              try_req <= REQ_NONE;
              state   <= ST_FALL;
            end
          end else begin
            cur_x        <= com_x;
            cur_y        <= com_y;
            cur_rotation <= com_rot;
            if (try_req == REQ_DROP || try_req == REQ_DOWN) begin
              place_piece <= 1'b1;
              state       <= ST_LOCK;
            end else begin
              try_req <= REQ_NONE;
              state   <= ST_FALL;
            end
          end
        end
        ST_LOCK: begin
          place_piece <= 1'b0;
          try_req     <= REQ_NONE;
          if (pieces_placed != 16'hFFFF) pieces_placed <= pieces_placed + 16'd1;
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          state <= ST_SPAWN;
        end
        ST_GAME_OVER: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_sequencer.sv
// Directed bench for piece_sequencer: a vector table for single moves plus
// hand-written sequences for gravity, hard drop, game over and async reset.
module tb_piece_sequencer;

  localparam int BTN_START = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_ROT   = 3;
  localparam int BTN_DROP  = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        btn_left;
  logic        btn_right;
  logic        btn_rot;
  logic        btn_drop;
  logic        collision;
  logic [3:0]  cur_x;
  logic [4:0]  cur_y;
  logic [2:0]  cur_piece;
  logic [1:0]  cur_rotation;
  logic        place_piece;
  logic        game_over;
  logic [15:0] pieces_placed;

  logic        force_all;
  logic        blk_y_en;
  logic [4:0]  blk_y;
  logic        blk_x_en;
  logic [3:0]  blk_x;

  int compared;
  int mismatched;
  int cyc;
  int place_cnt;
  logic seen_wrap;

  typedef struct {
    string      name;
    int         btn;
    logic       blk_en;
    logic [3:0] blk_col;
    logic [3:0] exp_x;
    logic [1:0] exp_rot;
    logic       chk_wrap;
  } vec_t;

  vec_t vecs[12];

  // Stand-in playfield: walls, floor, plus programmable blocking row/column.
  assign collision = force_all || (cur_y >= 5'd20) || (cur_x >= 4'd10) ||
                     (blk_y_en && cur_y == blk_y) || (blk_x_en && cur_x == blk_x);

  piece_sequencer #(
    .BOARD_WIDTH  (10),
    .BOARD_HEIGHT (20),
    .SPAWN_X      (3),
    .GRAVITY_DIV  (8),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_rot       (btn_rot),
    .btn_drop      (btn_drop),
    .collision     (collision),
    .cur_x         (cur_x),
    .cur_y         (cur_y),
    .cur_piece     (cur_piece),
    .cur_rotation  (cur_rotation),
    .place_piece   (place_piece),
    .game_over     (game_over),
    .pieces_placed (pieces_placed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (place_piece) place_cnt = place_cnt + 1;
    if (cur_x == 4'hF) seen_wrap = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared = compared + 1;
    if (act !== exp) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One-cycle pulse, driven on the falling edge so one rising edge samples it.
  task automatic applyStimulus(input int code);
    @(negedge clk);
    case (code)
      BTN_START: start     = 1'b1;
      BTN_LEFT:  btn_left  = 1'b1;
      BTN_RIGHT: btn_right = 1'b1;
      BTN_ROT:   btn_rot   = 1'b1;
      default:   btn_drop  = 1'b1;
    endcase
    @(negedge clk);
    start     = 1'b0;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_rot   = 1'b0;
    btn_drop  = 1'b0;
  endtask

  task automatic waitY(input logic [4:0] y, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (cur_y == y) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int t[6];
    int bad;

    compared = 0; mismatched = 0; cyc = 0; place_cnt = 0; seen_wrap = 1'b0;
    rst_n = 1'b0; start = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_rot = 1'b0; btn_drop = 1'b0;
    force_all = 1'b0; blk_y_en = 1'b0; blk_y = 5'd0; blk_x_en = 1'b0; blk_x = 4'd0;

    vecs[0]  = '{"rot_1",       BTN_ROT,   1'b0, 4'd0, 4'd3, 2'd1, 1'b0};
    vecs[1]  = '{"rot_2",       BTN_ROT,   1'b0, 4'd0, 4'd3, 2'd2, 1'b0};
    vecs[2]  = '{"rot_3",       BTN_ROT,   1'b0, 4'd0, 4'd3, 2'd3, 1'b0};
    vecs[3]  = '{"rot_wrap",    BTN_ROT,   1'b0, 4'd0, 4'd3, 2'd0, 1'b0};
    vecs[4]  = '{"left_reject", BTN_LEFT,  1'b1, 4'd2, 4'd3, 2'd0, 1'b0};
    vecs[5]  = '{"right_4",     BTN_RIGHT, 1'b0, 4'd0, 4'd4, 2'd0, 1'b0};
    vecs[6]  = '{"left_3",      BTN_LEFT,  1'b0, 4'd0, 4'd3, 2'd0, 1'b0};
    vecs[7]  = '{"left_2",      BTN_LEFT,  1'b0, 4'd0, 4'd2, 2'd0, 1'b0};
    vecs[8]  = '{"left_1",      BTN_LEFT,  1'b0, 4'd0, 4'd1, 2'd0, 1'b0};
    vecs[9]  = '{"left_0",      BTN_LEFT,  1'b0, 4'd0, 4'd0, 2'd0, 1'b0};
    vecs[10] = '{"left_at_0",   BTN_LEFT,  1'b0, 4'd0, 4'd0, 2'd0, 1'b1};
    vecs[11] = '{"right_1",     BTN_RIGHT, 1'b0, 4'd0, 4'd1, 2'd0, 1'b0};

    repeat (3) @(negedge clk);
    checkOutput("reset_cur_x", cur_x, 0);
    checkOutput("reset_cur_y", cur_y, 0);
    checkOutput("reset_piece", cur_piece, 0);
    checkOutput("reset_rot", cur_rotation, 0);
    checkOutput("reset_place", place_piece, 0);
    checkOutput("reset_game_over", game_over, 0);
    checkOutput("reset_placed", pieces_placed, 0);
    rst_n = 1'b1;

    // First spawn: LFSR still at seed 0xA5, so the piece code is 5.
    applyStimulus(BTN_START);
    @(negedge clk);
    @(negedge clk);
    checkOutput("spawn_x", cur_x, 3);
    checkOutput("spawn_y", cur_y, 0);
    checkOutput("spawn_rot", cur_rotation, 0);
    checkOutput("spawn_piece", cur_piece, 5);
    checkOutput("spawn_place", place_piece, 0);
    checkOutput("spawn_game_over", game_over, 0);

    // Gravity every 8 cycles until row 5 blocks.
    blk_y_en = 1'b1;
    blk_y    = 5'd5;
    for (int k = 1; k <= 5; k++) begin
      waitY(5'(k), 20, t[k]);
      checkOutput($sformatf("grav_reach_y%0d", k), (t[k] >= 0), 1);
    end
    for (int k = 2; k <= 5; k++) begin
      checkOutput($sformatf("grav_period_y%0d", k), t[k] - t[k-1], 8);
    end
    @(negedge clk);
    checkOutput("grav_lock_place", place_piece, 1);
    checkOutput("grav_lock_y", cur_y, 4);
    blk_y = 5'd12;
    @(negedge clk);
    checkOutput("grav_place_one_cycle", place_piece, 0);
    checkOutput("grav_placed_count", pieces_placed, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("respawn_y", cur_y, 0);
    checkOutput("respawn_x", cur_x, 3);

    // Hard drop: one TRY per cycle, blocked at row 12; left mid-drop is discarded.
    applyStimulus(BTN_DROP);
    bad = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (cur_y != 5'(k)) bad = bad + 1;
      if (k == 5) btn_left = 1'b1;
      if (k == 6) btn_left = 1'b0;
    end
    checkOutput("drop_try_sequence", bad, 0);
    @(negedge clk);
    checkOutput("drop_lock_place", place_piece, 1);
    checkOutput("drop_lock_y", cur_y, 11);
    @(negedge clk);
    checkOutput("drop_placed_count", pieces_placed, 2);
    @(negedge clk);
    @(negedge clk);
    checkOutput("drop_respawn_y", cur_y, 0);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (cur_x != 4'd3) bad = bad + 1;
    end
    checkOutput("drop_left_discarded", bad, 0);
    blk_y_en = 1'b0;

    for (int i = 0; i < 12; i++) begin
      blk_x_en  = vecs[i].blk_en;
      blk_x     = vecs[i].blk_col;
      seen_wrap = 1'b0;
      applyStimulus(vecs[i].btn);
      repeat (5) @(negedge clk);
      checkOutput({vecs[i].name, "_x"}, cur_x, vecs[i].exp_x);
      checkOutput({vecs[i].name, "_rot"}, cur_rotation, vecs[i].exp_rot);
      if (vecs[i].chk_wrap) checkOutput({vecs[i].name, "_no_try"}, seen_wrap, 0);
      blk_x_en = 1'b0;
    end

    // Everything collides: the drop locks, and the next spawn fails.
    force_all = 1'b1;
    place_cnt = 0;
    applyStimulus(BTN_DROP);
    repeat (30) @(negedge clk);
    checkOutput("go_place_once", place_cnt, 1);
    checkOutput("go_flag", game_over, 1);
    checkOutput("go_placed_count", pieces_placed, 3);
    place_cnt = 0;
    applyStimulus(BTN_START);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (game_over !== 1'b1) bad = bad + 1;
    end
    checkOutput("go_sticky", bad, 0);
    checkOutput("go_no_place", place_cnt, 0);

    // Async reset while a rotation trial is in flight.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    force_all = 1'b0;
    applyStimulus(BTN_START);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(BTN_ROT);
    @(posedge clk);
    #1;
    checkOutput("rst_pre_try_rot", cur_rotation, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_x", cur_x, 0);
    checkOutput("rst_async_rot", cur_rotation, 0);
    checkOutput("rst_async_game_over", game_over, 0);
    checkOutput("rst_async_placed", pieces_placed, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (cur_x != 4'd0 || cur_y != 5'd0 || place_piece != 1'b0) bad = bad + 1;
    end
    checkOutput("rst_idle_hold", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
